// File: rtl/sl_pkg.sv
// Shared SL definitions: config field layout, reset config, frequency codes
// and the transmit scheduler state encoding.
package sl_pkg;

    localparam int unsigned CFG_W = 10;
    localparam int unsigned BQL   = 0;
    localparam int unsigned BQH   = 5;
    localparam int unsigned IRQM  = 6;
    localparam int unsigned FQL   = 7;
    localparam int unsigned FQH   = 9;

    // Codes above SL_FQ_4 are forwarded untouched; the transmitter maps them to code 0.
    localparam logic [FQH-FQL:0] SL_FQ_0 = 3'd0;
    localparam logic [FQH-FQL:0] SL_FQ_1 = 3'd1;
    localparam logic [FQH-FQL:0] SL_FQ_2 = 3'd2;
    localparam logic [FQH-FQL:0] SL_FQ_3 = 3'd3;
    localparam logic [FQH-FQL:0] SL_FQ_4 = 3'd4;

    typedef struct packed {
        logic [FQH-FQL:0] freq;
        logic             irq;
        logic [BQH-BQL:0] bits;
    } sl_cfg_t;

    localparam sl_cfg_t SL_CFG_RST = '{freq: SL_FQ_2, irq: 1'b0, bits: 6'd8};

    typedef enum logic [6:0] {
        ST_IDLE       = 7'b0000001,
        ST_GRANT      = 7'b0000010,
        ST_LOAD       = 7'b0000100,
        ST_FIRE       = 7'b0001000,
        ST_WAIT_START = 7'b0010000,
        ST_WAIT_DONE  = 7'b0100000,
        ST_FINISH     = 7'b1000000
    } sched_state_e;

endpackage

// File: rtl/sl_tx_scheduler_if.sv
// Requester and transmitter signals of the SL transmit scheduler.
// master = requesters/transmitter side, slave = scheduler.
interface sl_tx_scheduler_if
    import sl_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 3
);
    logic [NREQ-1:0]       req;
    logic [32*NREQ-1:0]    req_data;
    logic [CFG_W*NREQ-1:0] req_cfg;
    logic [NREQ-1:0]       ack;
    logic [NREQ-1:0]       err;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic [31:0]           tx_data;
    logic                  tx_send;
    logic [CFG_W-1:0]      tx_cfg;
    logic                  tx_cfg_we;
    logic [CFG_W-1:0]      tx_cfg_rd;
    logic                  tx_busy;

    modport master (
        output req, req_data, req_cfg, tx_cfg_rd, tx_busy,
        input  ack, err, grant_id, busy, tx_data, tx_send, tx_cfg, tx_cfg_we
    );

    modport slave (
        input  req, req_data, req_cfg, tx_cfg_rd, tx_busy,
        output ack, err, grant_id, busy, tx_data, tx_send, tx_cfg, tx_cfg_we
    );
endinterface

// File: rtl/sl_rr_arbiter.sv
// Combinational rotating priority encoder: first set bit of req at or above
// ptr, wrapping NREQ-1 -> 0. ptr must be below NREQ.
module sl_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  idx,
    output logic            valid
);
    localparam int unsigned SW = IDW + 1;

    logic [NREQ-1:0] rot;
    logic [SW-1:0]   sum;

    always_comb begin
        rot   = NREQ'({req, req} >> ptr);
        valid = 1'b0;
        idx   = '0;
        sum   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!valid && rot[k]) begin
                valid = 1'b1;
                sum   = {1'b0, ptr} + SW'(k);
                if (sum >= SW'(NREQ)) begin
                    sum = sum - SW'(NREQ);
                end
                idx = sum[IDW-1:0];
            end
        end
    end
endmodule

// File: rtl/sl_tx_scheduler.sv
// Shares one SL transmitter among NREQ requesters: arbitrate, load config,
// send, and report ack/err per requester. SL_TX_SCHED_FIXED_PRIO_EN selects fixed priority.
module sl_tx_scheduler
    import sl_pkg::*;
#(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned START_TMO = 8,
    parameter int unsigned IDW       = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    sl_tx_scheduler_if.slave    bus
);
    localparam int unsigned NSLOT = 1 << IDW;
    localparam int unsigned CW    = (START_TMO > 1) ? $clog2(START_TMO) : 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);
    localparam logic [CW-1:0]  TMO_END = CW'(START_TMO - 1);

    sched_state_e    state_q, state_d;
    logic [IDW-1:0]  grant_q, grant_d;
    logic [IDW-1:0]  ptr_q, ptr_d, ptr_adv;
    logic [IDW-1:0]  win_idx;
    logic            win_valid;
    logic [31:0]     data_q, data_d;
    sl_cfg_t         cfg_q, cfg_d;
    logic            busy_q, busy_d;
    logic            send_q, send_d;
    logic            we_q, we_d;
    logic [NREQ-1:0] ack_q, ack_d, err_q, err_d;
    logic [NREQ-1:0] grant_oh;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [31:0]     data_slot [NSLOT];
    sl_cfg_t         cfg_slot  [NSLOT];

    // Unpack requester slices; slots past NREQ keep the index width exact.
    for (genvar i = 0; i < NSLOT; i++) begin : g_slot
        if (i < NREQ) begin : g_used
            assign data_slot[i] = bus.req_data[32*i +: 32];
            assign cfg_slot[i]  = sl_cfg_t'(bus.req_cfg[CFG_W*i +: CFG_W]);
        end else begin : g_pad
            assign data_slot[i] = '0;
            assign cfg_slot[i]  = '0;
        end
    end

    sl_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign grant_oh = {{(NREQ-1){1'b0}}, 1'b1} << grant_q;

`ifdef SL_TX_SCHED_FIXED_PRIO_EN
    assign ptr_adv = '0;
`else
    assign ptr_adv = (grant_q == LAST_ID) ? '0 : grant_q + IDW'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            data_q  <= '0;
            cfg_q   <= SL_CFG_RST;
            busy_q  <= 1'b0;
            send_q  <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            cfg_q   <= cfg_d;
            busy_q  <= busy_d;
            send_q  <= send_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are registered Moore-style: each *_d is the value for the state being entered.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        cfg_d   = cfg_q;
        busy_d  = busy_q;
        send_d  = 1'b0;
        we_d    = 1'b0;
        ack_d   = '0;
        err_d   = '0;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (win_valid && !bus.tx_busy) begin
                    state_d = ST_GRANT;
                    grant_d = win_idx;
                    data_d  = data_slot[win_idx];
                    cfg_d   = cfg_slot[win_idx];
                    busy_d  = 1'b1;
                end
            end
            ST_GRANT: begin
                if (!(|bus.req)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_LOAD;
                    we_d    = (cfg_q != bus.tx_cfg_rd);
                end
            end
            ST_LOAD: begin
                state_d = ST_FIRE;
                send_d  = 1'b1;
                cnt_d   = '0;
            end
            ST_FIRE: begin
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (bus.tx_busy) begin
                    state_d = ST_WAIT_DONE;
                end else if (cnt_q == TMO_END) begin
                    state_d = ST_FINISH;
                    err_d   = grant_oh;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_adv;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d = ST_FINISH;
                    ack_d   = grant_oh;
                    busy_d  = 1'b0;
                    ptr_d   = ptr_adv;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.grant_id  = grant_q;
    assign bus.busy      = busy_q;
    assign bus.tx_data   = data_q;
    assign bus.tx_send   = send_q;
    assign bus.tx_cfg    = cfg_q;
    assign bus.tx_cfg_we = we_q;
endmodule

// File: tb/tb_sl_tx_scheduler.sv
// Randomized bench for sl_tx_scheduler against a queue-free reference model
// of arbitration order, transmitter behaviour and pulse timing.
module tb_sl_tx_scheduler;
    localparam int unsigned NREQ      = 4;
    localparam int unsigned START_TMO = 8;
    localparam int unsigned IDW       = 3;
    localparam logic [9:0]  CFG_RST   = 10'b0100001000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sl_tx_scheduler_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    sl_tx_scheduler #(.NREQ(NREQ), .START_TMO(START_TMO), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // transmitter model
    logic [9:0] x_cfg;
    int x_dly, x_len, x_phase, x_cnt, t_fall;
    bit x_nostart, x_force;

    // requester model
    logic [31:0]     m_data [NREQ];
    logic [9:0]      m_cfg  [NREQ];
    logic [NREQ-1:0] m_req;
    int              m_ptr;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive_req();
        bus.req = m_req;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[32*i +: 32] = m_data[i];
            bus.req_cfg[10*i +: 10]  = m_cfg[i];
        end
    endtask

    // Expected winner: first requesting index from the start point, wrapping.
    function automatic int pick();
        int s;
`ifdef SL_TX_SCHED_FIXED_PRIO_EN
        s = 0;
`else
        s = m_ptr;
`endif
        for (int k = 0; k < NREQ; k++) begin
            if (m_req[(s + k) % NREQ]) return (s + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (bus.tx_cfg_we) x_cfg = bus.tx_cfg;
        if (x_phase == 2) begin
            x_cnt--;
            if (x_cnt == 0) begin
                x_phase = 0;
                t_fall  = cyc;
            end
        end else if (x_phase == 1) begin
            if (x_cnt == 0) begin
                x_phase = 2;
                x_cnt   = x_len;
            end else begin
                x_cnt--;
            end
        end
        if (bus.tx_send && x_phase == 0 && !x_nostart) begin
            if (x_dly == 0) begin
                x_phase = 2;
                x_cnt   = x_len;
            end else begin
                x_phase = 1;
                x_cnt   = x_dly - 1;
            end
        end
        bus.tx_busy   = (x_phase == 2) || x_force;
        bus.tx_cfg_rd = x_cfg;
        if (|(bus.ack | bus.err))
            chk("ackerr_onehot", 64'($countones(bus.ack | bus.err)), 64'd1);
    endtask

    task automatic do_xfer(input bit hold, input bit may_drop);
        int win, t_g, t_we, t_s, n_we;
        bit done, exp_we, exp_err;
        logic [31:0] ed;
        logic [9:0]  ec;
        win = pick();
        t_g = -1; t_we = -1; t_s = -1; n_we = 0; done = 0;
        ed = m_data[win];
        ec = m_cfg[win];
        exp_we  = (ec != x_cfg);
        exp_err = x_nostart;
        for (int n = 0; n < 80 && !done; n++) begin
            step();
            if (bus.busy && t_g < 0) begin
                t_g = cyc;
                chk("grant_id", 64'(bus.grant_id), 64'(win));
            end
            if (bus.tx_cfg_we) begin
                n_we++;
                t_we = cyc;
            end
            if (bus.tx_send) begin
                t_s = cyc;
                chk("tx_data", 64'(bus.tx_data), 64'(ed));
                chk("tx_cfg", 64'(bus.tx_cfg), 64'(ec));
                chk("grant_to_send", 64'(t_s - t_g), 64'd2);
                for (int i = 0; i < NREQ; i++) m_data[i] = $urandom;
                if (may_drop && $urandom_range(1, 0) == 1) m_req[win] = 1'b0;
                drive_req();
            end
            if (|(bus.ack | bus.err)) begin
                done = 1;
                if (exp_err) begin
                    chk("err_vec", 64'(bus.err), 64'd1 << win);
                    chk("ack_on_err", 64'(bus.ack), 64'd0);
                    chk("err_latency", 64'(cyc - t_s), 64'(START_TMO + 1));
                end else begin
                    chk("ack_vec", 64'(bus.ack), 64'd1 << win);
                    chk("err_on_ack", 64'(bus.err), 64'd0);
                    chk("ack_latency", 64'(cyc - t_fall), 64'd1);
                end
                chk("busy_at_end", 64'(bus.busy), 64'd0);
                if (!hold) m_req[win] = 1'b0;
                drive_req();
`ifndef SL_TX_SCHED_FIXED_PRIO_EN
                m_ptr = (win + 1) % NREQ;
`endif
            end
        end
        if (!done) chk("xfer_timeout", 64'd0, 64'd1);
        chk("cfg_we_count", 64'(n_we), 64'(exp_we));
        if (exp_we) chk("we_to_send", 64'(t_s - t_we), 64'd1);
    endtask

    initial begin
        bit seen;
        x_cfg = CFG_RST; x_dly = 1; x_len = 5; x_phase = 0; x_cnt = 0; t_fall = 0;
        x_nostart = 0; x_force = 0;
        m_ptr = 0; m_req = '0;
        for (int i = 0; i < NREQ; i++) begin
            m_data[i] = '0;
            m_cfg[i]  = CFG_RST;
        end
        drive_req();
        bus.tx_busy = 1'b0;
        bus.tx_cfg_rd = x_cfg;
        repeat (3) step();
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_ackerr", 64'({bus.ack, bus.err}), 64'd0);
        chk("rst_send_we", 64'({bus.tx_send, bus.tx_cfg_we}), 64'd0);
        chk("rst_grant", 64'(bus.grant_id), 64'd0);
        chk("rst_data", 64'(bus.tx_data), 64'd0);
        chk("rst_cfg", 64'(bus.tx_cfg), 64'(CFG_RST));
        rst_n = 1'b1;

        // single requester, new config, then the same config again
        m_req = 4'b0001; m_data[0] = 32'hA5A5_0F0F; m_cfg[0] = 10'b0110100000;
        drive_req();
        do_xfer(0, 0);
        m_req = 4'b0001; m_data[0] = 32'h1234_5678;
        drive_req();
        do_xfer(0, 0);

        // transmitter never starts
        x_nostart = 1; m_req = 4'b0100; m_data[2] = 32'h0BAD_F00D; m_cfg[2] = 10'h3C7;
        drive_req();
        do_xfer(0, 0);
        x_nostart = 0;

        // foreign transmission holds the scheduler in IDLE
        x_force = 1; bus.tx_busy = 1'b1;
        m_req = 4'b0010; m_data[1] = 32'hCAFE_0001; m_cfg[1] = 10'h0A5;
        drive_req();
        seen = 0;
        repeat (6) begin
            step();
            if (bus.busy) seen = 1;
        end
        chk("foreign_hold", 64'(seen), 64'd0);
        x_force = 0;
        do_xfer(0, 0);

        // asynchronous reset while waiting for the word to finish
        m_req = 4'b0100; m_data[2] = 32'hDEAD_BEEF; m_cfg[2] = 10'h155;
        x_dly = 0; x_len = 40;
        drive_req();
        seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            step();
            if (bus.tx_send) seen = 1;
        end
        chk("rst_send_seen", 64'(seen), 64'd1);
        repeat (3) step();
        chk("pre_rst_busy", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_grant", 64'(bus.grant_id), 64'd0);
        chk("arst_data", 64'(bus.tx_data), 64'd0);
        chk("arst_cfg", 64'(bus.tx_cfg), 64'(CFG_RST));
        x_phase = 0; m_req = '0; m_ptr = 0;
        drive_req();
        seen = 0;
        repeat (3) begin
            step();
            if (|(bus.ack | bus.err)) seen = 1;
        end
        chk("arst_no_pulse", 64'(seen), 64'd0);
        rst_n = 1'b1;
        x_dly = 1; x_len = 4;

        // all requesters held: round-robin order from pointer 0
        m_req = 4'b1111;
        for (int i = 0; i < NREQ; i++) m_cfg[i] = 10'($urandom);
        drive_req();
        for (int t = 0; t < 8; t++) do_xfer(1, 0);
        m_req = 4'b1010;
        drive_req();
        for (int t = 0; t < 4; t++) do_xfer(1, 0);
        m_req = '0;
        drive_req();

        // random traffic
        for (int t = 0; t < 30; t++) begin
            m_req = NREQ'($urandom_range(2**NREQ - 1, 1));
            for (int i = 0; i < NREQ; i++) begin
                m_data[i] = $urandom;
                m_cfg[i]  = ($urandom_range(2, 0) == 0) ? x_cfg : 10'($urandom);
            end
            x_dly = $urandom_range(2, 0);
            x_len = $urandom_range(6, 2);
            x_nostart = ($urandom_range(9, 0) == 0);
            drive_req();
            do_xfer(0, 1);
        end
        x_nostart = 0;
        m_req = '0;
        drive_req();
        repeat (4) step();
        chk("idle_at_end", 64'(bus.busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
